jpeg_block_sched: RTL and testbench
===================================

# jpeg_block_sched

Frame-level sequencer for the quantizer → RLC encoder pipeline. It accepts 8×8 DCT blocks from the upstream block buffer through a valid/ready handshake and issues exactly one `enable` pulse per block to the quantizer. It then waits for the encoder's `vaild` completion pulse before admitting the next block, so only one block is ever in flight. It also counts blocks and SRAM words per frame and flags stalled or spurious completions.

## Interface
Parameters:
- `BLK_W`, 11: width of the block count and index.
- `WORD_W`, 11: width of the SRAM word counter; matches `sram_waddr`.
- `TIMEOUT`, 64: maximum number of WAIT cycles allowed before the block is declared stalled.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `srst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- `num_blocks`  in  BLK_W  number of blocks in the frame; latched when `start` is honoured.
- `mode_cfg`  in  1  quantization table select; latched when `start` is honoured.
- `blk_valid`  in  1  upstream DCT block is present and stable on the dct bus.
- `blk_ready`  out  1  one-cycle accept; upstream may change the bus on the following cycle.
- `enable`  out  1  one-cycle pulse to the quantizer.
- `mode`  out  1  latched `mode_cfg`, held for the whole frame.
- `vaild`  in  1  encoder block-complete pulse.
- `wen`  in  1  encoder SRAM write strobe; used for counting only.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse at frame end, including aborted frames.
- `blk_idx`  out  BLK_W  index of the current block.
- `word_cnt`  out  WORD_W  number of SRAM words written in this frame.
- `err`  out  2  sticky status: bit0 = timeout, bit1 = spurious `vaild`.

## Operation
States:
- IDLE
  - `start` → latch `num_blocks` and `mode_cfg`; clear `blk_idx`, `word_cnt` and `err`.
  - If the latched `num_blocks` is 0 → go to DONE; otherwise → go to FETCH.
  - `start` in any state other than IDLE is ignored.
- FETCH
  - `blk_valid` → go to ISSUE.
  - No timeout applies in this state.
- ISSUE
  - Lasts exactly one cycle.
  - `enable` = 1 and `blk_ready` = 1; the watchdog is cleared; → go to WAIT.
- WAIT
  - The watchdog increments every cycle.
  - `vaild`, last block (`blk_idx` == `num_blocks`−1) → go to DONE.
  - `vaild`, not the last block → `blk_idx`+1 and go to FETCH.
  - Watchdog reaches `TIMEOUT`−1 without `vaild` → set `err[0]` and go to DONE (the frame is aborted).
  - `vaild` and watchdog expiry in the same cycle → `vaild` wins and no error is recorded.
- DONE
  - `frame_done` = 1 for one cycle; → go to IDLE.

Counters and error flags:
- `word_cnt` increments on every `wen` while `busy` is high and saturates at 2^WORD_W−1.
- `wen` is ignored in IDLE.
- `vaild` in any state other than WAIT sets `err[1]` and has no other effect.
- `err` is held until the next honoured `start`.

## Timing
- Reset: all outputs are 0 (`blk_ready`, `enable`, `mode`, `busy`, `frame_done`, `blk_idx`, `word_cnt`, `err`); the state is IDLE and the watchdog is 0.
- Reset asserted mid-frame forces IDLE immediately (asynchronously); no `frame_done` is produced.
- `start` to first `enable`: at least 2 cycles (IDLE→FETCH, FETCH→ISSUE), provided `blk_valid` is already high.
- `vaild` to the next `enable`: 2 cycles if `blk_valid` is already high.
- `frame_done` appears 1 cycle after the `vaild` of the last block.
- `num_blocks`=0: `frame_done` appears 2 cycles after `start`; `enable` never asserts.
- All outputs are registered or decoded directly from the state; no output has a combinational path from any input.

## Structure
- Package `jpeg_pkg` holds:
  - the state enum (IDLE, FETCH, ISSUE, WAIT, DONE);
  - `BLK_W`, `WORD_W` and the default `TIMEOUT`;
  - the `err` bit positions.
- Sub-module `sched_watchdog`: clearable up-counter that outputs an `expired` flag when the count reaches `TIMEOUT`−1.
- The FSM and both counters are in the top of this block.

## Test plan
- `num_blocks`=3 with `blk_valid` held high, `vaild` 5 cycles after each `enable` → exactly 3 `enable` pulses; `blk_idx` steps 0→1→2; one `frame_done`; `err`=0.
- `num_blocks`=0 → `frame_done` 2 cycles after `start`; no `enable`; `busy` high for 2 cycles.
- `TIMEOUT`=8 with `vaild` withheld → `err[0]`=1 and `frame_done` 8 cycles after the `enable`. A following `start` clears `err` to 0.
- `vaild` in IDLE and in FETCH → `err[1]`=1; `blk_idx` is unchanged; the FSM is not perturbed.
- 2100 `wen` pulses in one frame → `word_cnt` saturates at 2047. A `start` pulse during WAIT is ignored: `num_blocks` is unchanged.
- `srst_n` asserted in WAIT of block 1 of 4 → all outputs are 0 at once. After release plus `start`, the frame runs cleanly from `blk_idx`=0.

Source files
------------

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared types and constants for the JPEG block scheduler.
package jpeg_pkg;
    localparam int BLK_W        = 11;
    localparam int WORD_W       = 11;
    localparam int TIMEOUT      = 64;
    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_SPURIOUS = 1;
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_e;
endpackage

// File: rtl/jpeg_block_sched_if.sv
// jpeg_block_sched_if: block handshake and encoder feedback between the pipeline and the scheduler.
interface jpeg_block_sched_if;
    logic blk_valid;
    logic blk_ready;
    logic enable;
    logic vaild;
    logic wen;
    modport master (output blk_valid, vaild, wen, input blk_ready, enable);
    modport slave  (input blk_valid, vaild, wen, output blk_ready, enable);
endinterface

// File: rtl/sched_watchdog.sv
// sched_watchdog: clearable up-counter flagging the cycle whose increment lands on TIMEOUT-1.
module sched_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic srst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
    assign expired_o = en_i && !clr_i && cnt_d == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge srst_n)
        if (!srst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/jpeg_block_sched.sv
// jpeg_block_sched: admits one DCT block at a time into the quantizer/RLC pipeline,
// counting blocks and SRAM words per frame and flagging stalls and stray completions.
module jpeg_block_sched
    import jpeg_pkg::*;
#(
    parameter int BLK_W   = jpeg_pkg::BLK_W,
    parameter int WORD_W  = jpeg_pkg::WORD_W,
    parameter int TIMEOUT = jpeg_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic              start,
    input  logic [BLK_W-1:0]  num_blocks,
    input  logic              mode_cfg,
    jpeg_block_sched_if.slave bus,
    output logic              mode,
    output logic              busy,
    output logic              frame_done,
    output logic [BLK_W-1:0]  blk_idx,
    output logic [WORD_W-1:0] word_cnt,
    output logic [1:0]        err
);
    state_e state_q, state_d;
    logic [BLK_W-1:0] num_q, num_d, idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0] err_q, err_d, hit;
    logic mode_q, mode_d, take, in_wait, last, expired;

    sched_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk       (clk),
        .srst_n    (srst_n),
        .clr_i     (state_q == ISSUE),
        .en_i      (in_wait),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (num_q == '0) state_d = DONE; else if (bus.blk_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.vaild) state_d = last ? DONE : FETCH; else if (expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        take    = state_q == IDLE && start;
        in_wait = state_q == WAIT;
        last    = idx_q == num_q - BLK_W'(1);
        num_d   = take ? num_blocks : num_q;
        mode_d  = take ? mode_cfg : mode_q;
        idx_d   = take ? '0 : (in_wait && bus.vaild && !last) ? idx_q + BLK_W'(1) : idx_q;
        word_d  = take ? '0 : (busy && bus.wen && word_q != '1) ? word_q + WORD_W'(1) : word_q;
        hit     = '0;
        // a completion coinciding with expiry is a normal completion
        hit[ERR_TIMEOUT]  = in_wait && expired && !bus.vaild;
        hit[ERR_SPURIOUS] = bus.vaild && !in_wait;
        err_d   = take ? '0 : err_q | hit;
    end

    always_ff @(posedge clk or negedge srst_n)
        if (!srst_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            word_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end

    assign bus.enable    = state_q == ISSUE;
    assign bus.blk_ready = state_q == ISSUE;
    assign busy          = state_q != IDLE;
    assign frame_done    = state_q == DONE;
    assign mode          = mode_q;
    assign blk_idx       = idx_q;
    assign word_cnt      = word_q;
    assign err           = err_q;
endmodule

// File: tb/tb_jpeg_block_sched.sv
// tb_jpeg_block_sched: directed frames with a scoreboard of expected block indices and end-of-frame status.
module tb_jpeg_block_sched;
    import jpeg_pkg::*;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic srst_n = 1'b0;
    logic start = 1'b0;
    logic mode_cfg = 1'b0;
    logic [BLK_W-1:0] num_blocks = '0;
    logic mode, busy, frame_done;
    logic [BLK_W-1:0] blk_idx;
    logic [WORD_W-1:0] word_cnt;
    logic [1:0] err;

    jpeg_block_sched_if bus ();

    jpeg_block_sched #(.BLK_W(BLK_W), .WORD_W(WORD_W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .srst_n     (srst_n),
        .start      (start),
        .num_blocks (num_blocks),
        .mode_cfg   (mode_cfg),
        .bus        (bus.slave),
        .mode       (mode),
        .busy       (busy),
        .frame_done (frame_done),
        .blk_idx    (blk_idx),
        .word_cnt   (word_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int fd_cnt = 0;
    int exp_idx[$];
    int exp_err[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (srst_n) begin
        if (bus.enable) begin
            en_cnt++;
            chk("enable_expected", exp_idx.size() > 0, 1);
            if (exp_idx.size() > 0) chk("blk_idx_at_enable", blk_idx, exp_idx.pop_front());
            chk("blk_ready_with_enable", bus.blk_ready, 1);
        end
        if (frame_done) begin
            fd_cnt++;
            chk("frame_done_expected", exp_err.size() > 0, 1);
            if (exp_err.size() > 0) chk("err_at_frame_done", err, exp_err.pop_front());
        end
    end

    task automatic pulse_start(output int s);
        @(posedge clk); #1;
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_en(output int c);
        c = -1;
        for (int i = 0; i < 40 && c < 0; i++) begin
            @(negedge clk);
            if (bus.enable) c = cyc;
        end
        chk("enable_seen", c >= 0, 1);
    endtask

    task automatic wait_fd(output int c);
        c = -1;
        for (int i = 0; i < 40 && c < 0; i++) begin
            @(negedge clk);
            if (frame_done) c = cyc;
        end
        chk("frame_done_seen", c >= 0, 1);
    endtask

    task automatic run_block(input int gap, output int e, output int v);
        wait_en(e);
        repeat (gap) @(posedge clk);
        #1 bus.vaild = 1'b1;
        v = cyc;
        @(posedge clk); #1;
        bus.vaild = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_enable"}, bus.enable, 0);
        chk({tag, "_blk_ready"}, bus.blk_ready, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_mode"}, mode, 0);
        chk({tag, "_blk_idx"}, blk_idx, 0);
        chk({tag, "_word_cnt"}, word_cnt, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int s, e, v, vp, f, bc, fdc, en0, fd0;
        bus.blk_valid = 1'b0;
        bus.vaild = 1'b0;
        bus.wen = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk_all_zero("reset");
        srst_n = 1'b1;

        // three blocks, completion 5 cycles after each enable
        num_blocks = 3; mode_cfg = 1'b1; bus.blk_valid = 1'b1;
        exp_idx.push_back(0); exp_idx.push_back(1); exp_idx.push_back(2);
        exp_err.push_back(0);
        en0 = en_cnt;
        pulse_start(s);
        run_block(5, e, v);
        chk("start_to_enable", e, s + 2);
        chk("mode_latched", mode, 1);
        vp = v;
        run_block(5, e, v);
        chk("vaild_to_enable", e, vp + 2);
        run_block(5, e, v);
        wait_fd(f);
        chk("fd_after_last_vaild", f, v + 1);
        chk("enables_frame_a", en_cnt - en0, 3);
        chk("err_frame_a", err, 0);
        chk("blk_idx_end_a", blk_idx, 2);

        // stray completion while idle
        @(posedge clk); #1 bus.vaild = 1'b1;
        @(posedge clk); #1 bus.vaild = 1'b0;
        chk("spurious_idle_err", err, 2);
        chk("spurious_idle_idx", blk_idx, 2);
        chk("spurious_idle_busy", busy, 0);

        // empty frame
        num_blocks = 0; mode_cfg = 1'b0;
        exp_err.push_back(0);
        en0 = en_cnt;
        pulse_start(s);
        chk("start_clears_err", err, 0);
        bc = 0; fdc = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bc += int'(busy);
            if (frame_done) fdc = cyc;
        end
        chk("empty_fd_latency", fdc, s + 2);
        chk("empty_busy_cycles", bc, 2);
        chk("empty_no_enable", en_cnt - en0, 0);
        chk("empty_mode", mode, 0);

        // stalled block: encoder never completes
        num_blocks = 1; bus.blk_valid = 1'b1;
        exp_idx.push_back(0); exp_err.push_back(1);
        pulse_start(s);
        wait_en(e);
        wait_fd(f);
        chk("timeout_fd_latency", f, e + TO);
        chk("timeout_err", err, 1);

        // next frame clears err; completion lands on the expiry cycle
        exp_idx.push_back(0); exp_err.push_back(0);
        pulse_start(s);
        chk("restart_clears_err", err, 0);
        run_block(TO - 1, e, v);
        wait_fd(f);
        chk("vaild_wins_fd", f, v + 1);
        chk("vaild_wins_err", err, 0);

        // stray completion in FETCH
        num_blocks = 2; bus.blk_valid = 1'b0;
        exp_idx.push_back(0); exp_idx.push_back(1); exp_err.push_back(2);
        en0 = en_cnt;
        pulse_start(s);
        bus.vaild = 1'b1;
        @(posedge clk); #1 bus.vaild = 1'b0;
        chk("spurious_fetch_err", err, 2);
        chk("spurious_fetch_idx", blk_idx, 0);
        chk("spurious_fetch_busy", busy, 1);
        repeat (2) @(posedge clk); #1;
        chk("spurious_fetch_no_enable", en_cnt - en0, 0);
        bus.blk_valid = 1'b1;
        run_block(3, e, v);
        run_block(3, e, v);
        wait_fd(f);
        chk("spurious_fetch_fd", f, v + 1);

        // word counter saturation, start ignored while busy
        num_blocks = 1; bus.blk_valid = 1'b0;
        exp_idx.push_back(0); exp_err.push_back(0);
        en0 = en_cnt;
        pulse_start(s);
        bus.wen = 1'b1;
        repeat (100) @(posedge clk); #1;
        chk("word_cnt_100", word_cnt, 100);
        repeat (2000) @(posedge clk); #1;
        bus.wen = 1'b0;
        chk("word_cnt_saturated", word_cnt, 2047);
        bus.blk_valid = 1'b1;
        wait_en(e);
        @(posedge clk); #1 start = 1'b1; num_blocks = 5;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 bus.vaild = 1'b1;
        v = cyc;
        @(posedge clk); #1 bus.vaild = 1'b0;
        wait_fd(f);
        chk("start_in_wait_ignored_fd", f, v + 1);
        chk("start_in_wait_enables", en_cnt - en0, 1);
        chk("word_cnt_held", word_cnt, 2047);

        // reset during WAIT of block 1 of 4
        num_blocks = 4; mode_cfg = 1'b1;
        exp_idx.push_back(0); exp_idx.push_back(1);
        pulse_start(s);
        run_block(2, e, v);
        wait_en(e);
        @(posedge clk); #1 bus.wen = 1'b1;
        @(posedge clk); #1 bus.wen = 1'b0;
        chk("pre_reset_word_cnt", word_cnt, 1);
        chk("pre_reset_idx", blk_idx, 1);
        chk("pre_reset_busy", busy, 1);
        fd0 = fd_cnt;
        srst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        repeat (2) @(posedge clk); #1;
        srst_n = 1'b1;
        chk("no_fd_on_reset", fd_cnt - fd0, 0);

        num_blocks = 2;
        exp_idx.push_back(0); exp_idx.push_back(1); exp_err.push_back(0);
        pulse_start(s);
        run_block(4, e, v);
        chk("post_reset_start_to_enable", e, s + 2);
        run_block(4, e, v);
        wait_fd(f);
        chk("post_reset_fd", f, v + 1);
        chk("post_reset_err", err, 0);

        // wen while idle is not counted
        @(posedge clk); #1 bus.wen = 1'b1;
        repeat (3) @(posedge clk); #1;
        bus.wen = 1'b0;
        chk("idle_wen_ignored", word_cnt, 0);

        repeat (2) @(posedge clk); #1;
        chk("exp_idx_drained", exp_idx.size(), 0);
        chk("exp_err_drained", exp_err.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
